mult_div_unit: RTL

Iterative multiply/divide unit owning the architectural HI/LO registers of the MIPS core, parametrised in operand width. It executes MULT/MULTU/DIV/DIVU as radix-2 multi-cycle operations and MTHI/MTLO as single-cycle writes. HI/LO are exposed continuously for MFHI/MFLO. It sits beside the ALU in execute; the pipeline stalls HI/LO readers and new mult/div issue on `busy`.

---
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// MULT/DIV run WIDTH iterations then a FIX cycle; MTHI/MTLO write at accept.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d, negr_q, negr_d;
    logic               dz_q, dz_d, isdiv_q, isdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d, pend_q, pend_d;

    logic             accept, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] rem_new, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = start_i && ready_o && !flush_i && (op_i <= OP_MTLO);
    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_neg     = signed_op && a_i[WIDTH-1];
    assign b_neg     = signed_op && b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // Multiply: add multiplicand into the top half on LSB, then shift right with carry.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    // Divide: partial remainder (one bit wider after shift) minus divisor; restore on borrow.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign rem_new   = div_trial[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0];

    assign prod_fix  = neg_q  ? -acc_q : acc_q;
    assign quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = pend_q;
        dbz_d   = 1'b0;
        pend_d  = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                case (op_i)
                    OP_MULTU, OP_MULT: begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        dz_d    = 1'b0;
                        isdiv_d = 1'b0;
                    end
                    OP_DIVU, OP_DIV: begin
                        isdiv_d = 1'b1;
                        if (b_i == '0) begin
                            state_d = S_FIX;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_DIV;
                            cnt_d   = CW'(WIDTH - 1);
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opb_d   = b_mag;
                            neg_d   = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            dz_d    = 1'b0;
                        end
                    end
                    OP_MTHI: begin
                        hi_d   = a_i;
                        pend_d = 1'b1;
                    end
                    OP_MTLO: begin
                        lo_d   = a_i;
                        pend_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MUL, S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = (state_q == S_MUL) ? {mul_sum, acc_q[WIDTH-1:1]}
                                               : {rem_new, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        dbz_d = 1'b1;
                    end else if (isdiv_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            pend_q  <= pend_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign busy_o        = ~ready_o;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
endmodule
